fetch_stage: RTL
================

// Module: fetch_stage
// PURPOSE
//   Instruction-fetch front end sitting between pc_register and the decode stage.
//   Drives pc_register (pc_in/load) and the synchronous instruction memory.
//   Buffers returned instructions with their PC in a DEPTH-entry FIFO.
//   Presents them to decode through a valid/ready handshake; handles branch redirects from EX.
// PARAMETERS
//   N        32  PC / address width
//   INSTR_W  32  instruction width
//   DEPTH    2   fetch-buffer entries; power of 2, >= 2
//   PC_STEP  4   sequential PC increment (bytes)
// PORTS
//   clk              in   1        clock, rising edge
//   clr              in   1        reset, asynchronous, active-low
//   pc_cur           in   N        current PC (pc_register.pc_out)
//   pc_next          out  N        next PC (to pc_register.pc_in)
//   pc_load          out  1        load strobe (to pc_register.load)
//   imem_req         out  1        instruction-memory read request
//   imem_addr        out  N        read address
//   imem_rdata       in   INSTR_W  read data, valid exactly 1 cycle after imem_req
//   redirect_valid   in   1        taken branch/jump from EX
//   redirect_target  in   N        redirect PC
//   id_valid         out  1        head entry available to decode
//   id_ready         in   1        decode accepts head entry
//   id_instr         out  INSTR_W  head instruction
//   id_pc            out  N        PC of head instruction
//   fb_count         out  log2(DEPTH)+1  current buffer occupancy
// BEHAVIOUR
//   State: buf_instr/buf_pc[DEPTH], wr_ptr, rd_ptr, count, inflight (1b), inflight_pc.
//   Reset (clr=0, async): all state 0. id_valid=0, id_instr=0, id_pc=0, fb_count=0.
//     pc_load, imem_req, pc_next, imem_addr are forced 0 while clr=0.
//   pop   = id_valid & id_ready & ~redirect_valid
//   issue = ~redirect_valid & (count + inflight - pop < DEPTH), evaluated combinationally.
//   imem_req = issue; imem_addr = pc_cur.
//   Normal cycle: pc_load = issue; pc_next = pc_cur + PC_STEP (mod 2^N, wraps silently).
//   On issue: inflight <= 1, inflight_pc <= pc_cur. Otherwise inflight <= 0.
//   Response: when inflight=1, imem_rdata is pushed with inflight_pc at wr_ptr.
//     Credit check guarantees no overflow.
//   Push and pop in the same cycle: count unchanged; both pointers advance, wrapping mod DEPTH.
//   id_valid = (count != 0); id_instr/id_pc = head entry (combinational from registers).
//     Zero-latency bypass from imem_rdata is not allowed; fetch-to-decode latency is 2 cycles.
//   Redirect (redirect_valid=1), highest priority:
//     pc_load=1, pc_next=redirect_target, imem_req=0.
//     count<=0, rd_ptr<=wr_ptr, inflight<=0; any response arriving this cycle is discarded.
//     No pop occurs, even if id_ready=1.
//     Next cycle: fetch from redirect_target.
//   Back-to-back redirects: the last one wins; no fetch issues while redirect_valid stays high.
//   Decode stall (id_ready=0): buffer fills to DEPTH, then issue=0 and pc_load=0, so PC holds.
//   Steady state with id_ready=1: one instruction per cycle after a 2-cycle fill.
//   Reset mid-operation: all state cleared immediately.
//     The first cycle after release issues imem_addr = pc_cur (0 from pc_register).
// TESTING
//   1 Release clr, id_ready=1, imem returns addr>>2.
//     -> imem_addr 0,4,8,... on consecutive cycles.
//     -> id_valid from cycle 2; id_pc 0,4,8; id_instr 0,1,2; one per cycle.
//   2 Hold id_ready=0 from reset.
//     -> exactly DEPTH=2 fetches issued (PC 0,4); fb_count=2.
//     -> pc_load=0 and pc_cur holds at 8.
//     -> raise id_ready: entries drain in order (0,4), then fetch resumes at 8.
//   3 Redirect to 0x100 with 1 buffered entry and 1 in flight.
//     -> next cycle fb_count=0, id_valid=0, imem_addr=0x100.
//     -> stale response never reaches id_instr; first id_pc after redirect is 0x100.
//   4 Redirect asserted together with id_ready=1 and id_valid=1.
//     -> no pop counted; buffer flushed; pc_next=target.
//   5 Start pc_cur=0xFFFFFFFC.
//     -> pc_next=0x00000000; next fetch at 0; no stall.
//   6 Assert clr low mid-stream with fb_count=2.
//     -> id_valid, fb_count, imem_req, pc_load all 0 immediately (before any clk edge).

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction-fetch front end: steps the PC, issues synchronous imem reads,
// buffers returned instructions with their PC and hands them to decode.
module fetch_stage #(
  parameter int unsigned N       = 32,
  parameter int unsigned INSTR_W = 32,
  parameter int unsigned DEPTH   = 2,
  parameter int unsigned PC_STEP = 4
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic [N-1:0]             pc_cur,
  output logic [N-1:0]             pc_next,
  output logic                     pc_load,
  output logic                     imem_req,
  output logic [N-1:0]             imem_addr,
  input  logic [INSTR_W-1:0]       imem_rdata,
  input  logic                     redirect_valid,
  input  logic [N-1:0]             redirect_target,
  output logic                     id_valid,
  input  logic                     id_ready,
  output logic [INSTR_W-1:0]       id_instr,
  output logic [N-1:0]             id_pc,
  output logic [$clog2(DEPTH):0]   fb_count
);

  localparam int unsigned PW  = $clog2(DEPTH);
  localparam int unsigned CW  = PW + 1;
  localparam int unsigned CW1 = CW + 1;

  // Fetch buffer storage and bookkeeping
  logic [INSTR_W-1:0] buf_instr [DEPTH];
  logic [N-1:0]       buf_pc    [DEPTH];
  logic [PW-1:0]      wr_ptr, rd_ptr;
  logic [CW-1:0]      count;
  logic               inflight;
  logic [N-1:0]       inflight_pc;

  // Next-state values
  logic [PW-1:0]      wr_ptr_d, rd_ptr_d;
  logic [CW-1:0]      count_d;
  logic               inflight_d;
  logic [N-1:0]       inflight_pc_d;

  // Handshake / credit terms
  logic               pop_c;
  logic               push_c;
  logic               issue_c;
  logic [CW1-1:0]     credit_c;

  // Pop, push and issue decisions; a redirect suppresses all three
  always_comb begin
    pop_c    = 1'b0;
    push_c   = 1'b0;
    issue_c  = 1'b0;
    credit_c = '0;
    pop_c    = (count != '0) & id_ready & ~redirect_valid;
    push_c   = inflight & ~redirect_valid;
    // Pop implies count >= 1, so this never underflows
    credit_c = CW1'(count) + CW1'(inflight) - CW1'(pop_c);
    issue_c  = ~redirect_valid & (credit_c < CW1'(DEPTH));
  end

  // PC / imem drive; everything forced low while in reset
  always_comb begin
    pc_load   = 1'b0;
    pc_next   = '0;
    imem_req  = 1'b0;
    imem_addr = '0;
    if (clr) begin
      imem_addr = pc_cur;
      imem_req  = issue_c;
      if (redirect_valid) begin
        pc_load = 1'b1;
        pc_next = redirect_target;
      end else begin
        pc_load = issue_c;
        pc_next = pc_cur + N'(PC_STEP);
      end
    end
  end

  // Next-state for pointers, occupancy and the in-flight tracker
  always_comb begin
    wr_ptr_d      = wr_ptr;
    rd_ptr_d      = rd_ptr;
    count_d       = count;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc;
    if (redirect_valid) begin
      // Flush: drop buffered entries and the outstanding response
      count_d    = '0;
      rd_ptr_d   = wr_ptr;
      inflight_d = 1'b0;
    end else begin
      if (push_c) wr_ptr_d = wr_ptr + PW'(1);
      if (pop_c)  rd_ptr_d = rd_ptr + PW'(1);
      count_d    = count + CW'(push_c) - CW'(pop_c);
      inflight_d = issue_c;
      if (issue_c) inflight_pc_d = pc_cur;
    end
  end

  // Control state register
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else begin
      wr_ptr      <= wr_ptr_d;
      rd_ptr      <= rd_ptr_d;
      count       <= count_d;
      inflight    <= inflight_d;
      inflight_pc <= inflight_pc_d;
    end
  end

  // Buffer write of the returning response at the write pointer
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      for (int i = 0; i < DEPTH; i++) begin
        buf_instr[i] <= '0;
        buf_pc[i]    <= '0;
      end
    end else if (push_c) begin
      buf_instr[wr_ptr] <= imem_rdata;
      buf_pc[wr_ptr]    <= inflight_pc;
    end
  end

  // Decode-side view of the head entry; no bypass from imem_rdata
  always_comb begin
    id_valid = (count != '0);
    id_instr = buf_instr[rd_ptr];
    id_pc    = buf_pc[rd_ptr];
    fb_count = count;
  end

endmodule
